mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DW, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter AW, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for bus_ack_i.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port op_valid_i  in  1  accept request when unit idle.
REQ-007 SHALL have port aluop_i  in  8  operation code: LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
REQ-008 SHALL have port addr_i  in  AW  effective byte address.
REQ-009 SHALL have port wdata_i  in  32  store source (reg2).
REQ-010 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_addr_o out AW, bus_sel_o out DW/8, bus_wdata_o out DW, bus_rdata_i in DW, bus_ack_i in 1.
REQ-011 SHALL have ports stall_req_o out 1, res_valid_o out 1, res_data_o out 32, err_o out 1, llbit_o out 1.

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; op_valid_i is sampled only in IDLE.
REQ-013 In IDLE, a valid aligned op SHALL register address, byte-lane select and store data, then enter REQ next cycle.
REQ-014 Lanes SHALL be big-endian: lowest byte address maps to the MSB lane; for DW=64, addr[2] selects the upper (0) or lower (1) word.
REQ-015 Stores SHALL replicate the byte or half across all lanes; sel SHALL mark only the addressed lanes.
REQ-016 In REQ, bus_req_o SHALL stay high with stable addr/sel/wdata/we until the cycle bus_ack_i=1; on ack, the FSM goes to DONE.
REQ-017 The load result SHALL be captured from bus_rdata_i on the ack cycle; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-018 In DONE, res_valid_o SHALL be high for exactly 1 cycle with res_data_o valid; stores return res_data_o=0.
REQ-019 stall_req_o SHALL be high from the accept cycle through the ack cycle, and low in DONE.
REQ-020 Minimum latency (ack on the first REQ cycle) SHALL be accept to res_valid_o = 2 cycles.
REQ-021 A 16-bit wait counter SHALL clear on entry to REQ and increment per cycle without ack; at count==TIMEOUT the FSM drops bus_req_o, goes to DONE with err_o=1, res_data_o=0.
REQ-022 Misaligned half (addr[0]=1) or word (addr[1:0]!=0) SHALL produce no bus cycle: IDLE -> DONE next cycle, err_o=1, stall_req_o high only in the accept cycle.
REQ-023 err_o SHALL be valid only while res_valid_o=1, and 0 otherwise.
REQ-024 An unknown aluop_i SHALL be ignored: remain IDLE, no stall.
REQ-025 If ack and timeout coincide, ack SHALL win (err_o=0).

Reset
REQ-026 Asserting rst at any time, including mid-REQ, SHALL force IDLE, drop bus_req_o the same cycle (async), and drive all outputs 0, counter 0, llbit 0.
REQ-027 bus_sel_o SHALL be 0 when bus_req_o=0.

Configuration
REQ-028 With MEM_LSU_LLSC_EN defined: LL behaves as LW and sets llbit on ack; SC with llbit=1 performs SW, clears llbit and returns 1; SC with llbit=0 issues no bus cycle (IDLE -> DONE) and returns 0; llbit_o shows llbit.
REQ-029 Without MEM_LSU_LLSC_EN: LL/SC are treated as unknown ops (REQ-024), and llbit_o is tied 0.

Structure
REQ-030 Op codes, FSM state encoding and DW-legal constants SHALL live in shared package lsu_pkg.
REQ-031 Lane select/replicate and load extract/extend SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-032 LB at addr 0x1001, rdata 0x11F23344, ack on first REQ cycle -> sel 0100, res_data 0xFFFFFFF2 two cycles after accept.
REQ-033 SH 0xABCD1234 at 0x2002, ack after 3 wait cycles -> sel 0011, wdata 0x12341234, stall_req_o high 5 cycles.
REQ-034 LW at 0x3001 -> no bus_req_o, res_valid_o with err_o=1 on the next cycle.
REQ-035 TIMEOUT=4, LW with ack never raised -> bus_req_o drops after 4 wait cycles, err_o=1, res_data 0.
REQ-036 DW=64, LHU at 0x0006, rdata 0x00000000_0000BEEF -> sel 00000011, res_data 0x0000BEEF.
REQ-037 (LLSC_EN) LL then SC returns 1 and writes; a second SC returns 0 with no bus cycle; rst pulsed mid-REQ clears llbit and drops bus_req_o immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared definitions for the mem_lsu load/store unit.
//   * aluop_i operation codes (LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC)
//   * FSM state encoding and access-size encoding
//   * legal data-bus widths
//   * lsu_decode(): turns an op code into a small control struct
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Operation codes carried on aluop_i
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;
  localparam logic [7:0] OP_LL  = 8'h30;
  localparam logic [7:0] OP_SC  = 8'h38;

  // Only these data-bus widths are supported
  localparam int DW_32 = 32;
  localparam int DW_64 = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Access size; the encoding is log2 of the byte count
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      known;  // recognised op code
    logic      store;  // write access (SB/SH/SW/SC)
    logic      sext;   // sign-extend load result
    logic      ll;     // load-linked
    logic      sc;     // store-conditional
    lsu_size_e size;
  } lsu_dec_t;

  function automatic lsu_dec_t lsu_decode(input logic [7:0] op);
    lsu_dec_t d;
    d.known = 1'b1;
    d.store = 1'b0;
    d.sext  = 1'b0;
    d.ll    = 1'b0;
    d.sc    = 1'b0;
    d.size  = SZ_WORD;
    case (op)
      OP_LB:   begin d.sext = 1'b1; d.size = SZ_BYTE; end
      OP_LBU:  d.size = SZ_BYTE;
      OP_LH:   begin d.sext = 1'b1; d.size = SZ_HALF; end
      OP_LHU:  d.size = SZ_HALF;
      OP_LW:   d.size = SZ_WORD;
      OP_SB:   begin d.store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:   begin d.store = 1'b1; d.size = SZ_HALF; end
      OP_SW:   d.store = 1'b1;
      OP_LL:   d.ll = 1'b1;
      OP_SC:   begin d.store = 1'b1; d.sc = 1'b1; end
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align -- purely combinational big-endian lane steering.
// Store side: byte-lane select for the addressed bytes and replication of the
// byte/half/word across the whole bus. Load side: pick the addressed bytes out
// of the read bus and sign- or zero-extend them to 32 bits.
// Lane NB-1 (the MSB byte) holds the lowest byte address.
// Ports:
//   st_size_i, st_off_i, st_data_i  store access size, byte offset, source data
//   sel_o, wdata_o                  lane select / replicated write data
//   ld_size_i, ld_sext_i, ld_off_i  load access size, sign flag, byte offset
//   rdata_i, ld_data_o              raw read bus / extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  lsu_size_e                 st_size_i,
  input  logic [$clog2(DW/8)-1:0]   st_off_i,
  input  logic [31:0]               st_data_i,
  output logic [DW/8-1:0]           sel_o,
  output logic [DW-1:0]             wdata_o,
  input  lsu_size_e                 ld_size_i,
  input  logic                      ld_sext_i,
  input  logic [$clog2(DW/8)-1:0]   ld_off_i,
  input  logic [DW-1:0]             rdata_i,
  output logic [31:0]               ld_data_o
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam logic [OW+1:0] NB_W = NB[OW+1:0];

  // Two spare bits so offset + size never wraps
  logic [OW+1:0] st_nb;
  logic [OW+1:0] st_off_w;
  logic [OW+1:0] ld_nb;
  logic [OW+1:0] ld_shift;
  logic [31:0]   ld_word;

  assign st_nb    = {{(OW+1){1'b0}}, 1'b1} << st_size_i;
  assign st_off_w = {2'b00, st_off_i};

  // Lane gi carries byte offset NB-1-gi; select it when inside the access
  for (genvar gi = 0; gi < NB; gi++) begin : g_sel
    localparam int LANE_OFF = NB - 1 - gi;
    assign sel_o[gi] = (LANE_OFF >= int'(st_off_w)) &&
                       (LANE_OFF < int'(st_off_w) + int'(st_nb));
  end

  always_comb begin
    case (st_size_i)
      SZ_BYTE: wdata_o = {NB{st_data_i[7:0]}};
      SZ_HALF: wdata_o = {(NB/2){st_data_i[15:0]}};
      default: wdata_o = {(NB/4){st_data_i}};
    endcase
  end

  // Shift the addressed bytes down to bit 0: the access ends at lane
  // NB - size - offset counted from the LSB lane.
  assign ld_nb    = {{(OW+1){1'b0}}, 1'b1} << ld_size_i;
  assign ld_shift = NB_W - ld_nb - {2'b00, ld_off_i};
  assign ld_word  = 32'(rdata_i >> {ld_shift, 3'b000});

  always_comb begin
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{ld_sext_i & ld_word[7]}}, ld_word[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_sext_i & ld_word[15]}}, ld_word[15:0]};
      default: ld_data_o = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- single-outstanding load/store unit with a request/ack memory bus.
// FSM IDLE -> REQ -> DONE -> IDLE. Misaligned ops and failed SC skip REQ.
// A 16-bit wait counter aborts the bus cycle after TIMEOUT cycles without ack.
// Optional feature macro: MEM_LSU_LLSC_EN enables LL/SC and the link bit;
// without it LL/SC are ignored like any unknown op and llbit_o is 0.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   op_valid_i, aluop_i, addr_i, wdata_i   request from the pipeline
//   bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
//   bus_rdata_i, bus_ack_i        memory bus
//   stall_req_o                   pipeline stall while the access is open
//   res_valid_o, res_data_o, err_o        one-cycle result
//   llbit_o                       current link bit
// -----------------------------------------------------------------------------
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid_i,
  input  logic [7:0]      aluop_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [31:0]     wdata_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW/8-1:0] bus_sel_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic [DW-1:0]   bus_rdata_i,
  input  logic            bus_ack_i,
  output logic            stall_req_o,
  output logic            res_valid_o,
  output logic [31:0]     res_data_o,
  output logic            err_o,
  output logic            llbit_o
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  lsu_state_e      state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  lsu_size_e       size_q, size_d;
  logic            sext_q, sext_d;
  logic            ll_q, ll_d;
  logic            sc_q, sc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic            err_q, err_d;
  logic            llbit_q, llbit_d;

  lsu_dec_t        dec;
  logic            op_known;
  logic            misaligned;
  logic            accept;
  logic [NB-1:0]   sel_new;
  logic [DW-1:0]   wdata_new;
  logic [31:0]     ld_data;
  logic [15:0]     cnt_inc;

  assign dec = lsu_decode(aluop_i);

`ifdef MEM_LSU_LLSC_EN
  assign op_known = dec.known;
  assign llbit_o  = llbit_q;
`else
  assign op_known = dec.known & ~dec.ll & ~dec.sc;
  assign llbit_o  = 1'b0;
`endif

  assign misaligned = ((dec.size == SZ_HALF) && addr_i[0]) ||
                      ((dec.size == SZ_WORD) && (addr_i[1:0] != 2'b00));
  assign accept     = op_valid_i && (state_q == ST_IDLE) && op_known;
  assign cnt_inc    = cnt_q + 16'd1;

  // Store steering uses the incoming request; load extraction uses the
  // registered access so it lines up with the ack cycle.
  mem_lane_align #(.DW(DW)) u_align (
    .st_size_i (dec.size),
    .st_off_i  (addr_i[OW-1:0]),
    .st_data_i (wdata_i),
    .sel_o     (sel_new),
    .wdata_o   (wdata_new),
    .ld_size_i (size_q),
    .ld_sext_i (sext_q),
    .ld_off_i  (addr_q[OW-1:0]),
    .rdata_i   (bus_rdata_i),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    sext_d      = sext_q;
    ll_d        = ll_q;
    sc_d        = sc_q;
    cnt_d       = cnt_q;
    llbit_d     = llbit_q;
    // Result fields live for exactly the one DONE cycle
    res_valid_d = 1'b0;
    res_data_d  = '0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            err_d       = 1'b1;
          end else if (dec.sc && !llbit_q) begin
            // Lost reservation: no bus cycle, result 0
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
          end else begin
            state_d   = ST_REQ;
            bus_req_d = 1'b1;
            we_d      = dec.store;
            addr_d    = addr_i;
            sel_d     = sel_new;
            wdata_d   = wdata_new;
            size_d    = dec.size;
            sext_d    = dec.sext;
            ll_d      = dec.ll;
            sc_d      = dec.sc;
            cnt_d     = '0;
          end
        end
      end
      ST_REQ: begin
        // Ack is checked first so it wins over a coinciding timeout
        if (bus_ack_i) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          we_d        = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = we_q ? {31'b0, sc_q} : ld_data;
          if (ll_q) llbit_d = 1'b1;
          if (sc_q) llbit_d = 1'b0;
        end else if (cnt_inc >= TIMEOUT_W) begin
          state_d     = ST_DONE;
          bus_req_d   = 1'b0;
          we_d        = 1'b0;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          cnt_d       = cnt_inc;
          if (sc_q) llbit_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      sext_q      <= 1'b0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      llbit_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      ll_q        <= ll_d;
      sc_q        <= sc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
      llbit_q     <= llbit_d;
    end
  end

  assign stall_req_o = accept || (state_q == ST_REQ);
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_sel_o   = bus_req_q ? sel_q : '0;
  assign bus_wdata_o = wdata_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- directed checks of mem_lsu: a 32-bit instance with TIMEOUT=4
// and a 64-bit instance with the default timeout. One line per transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        a_op_valid, a_ack, a_req, a_we, a_stall, a_rv, a_err, a_ll;
  logic [7:0]  a_aluop;
  logic [31:0] a_addr, a_wdata, a_rdata, a_baddr, a_bwdata, a_res;
  logic [3:0]  a_sel;

  // 64-bit instance
  logic        b_op_valid, b_ack, b_req, b_we, b_stall, b_rv, b_err, b_ll;
  logic [7:0]  b_aluop;
  logic [31:0] b_addr, b_wdata, b_baddr, b_res;
  logic [63:0] b_rdata, b_bwdata;
  logic [7:0]  b_sel;

  mem_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst(rst), .op_valid_i(a_op_valid), .aluop_i(a_aluop),
    .addr_i(a_addr), .wdata_i(a_wdata), .bus_req_o(a_req), .bus_we_o(a_we),
    .bus_addr_o(a_baddr), .bus_sel_o(a_sel), .bus_wdata_o(a_bwdata),
    .bus_rdata_i(a_rdata), .bus_ack_i(a_ack), .stall_req_o(a_stall),
    .res_valid_o(a_rv), .res_data_o(a_res), .err_o(a_err), .llbit_o(a_ll)
  );

  mem_lsu #(.DW(64), .AW(32)) u_dut_b (
    .clk(clk), .rst(rst), .op_valid_i(b_op_valid), .aluop_i(b_aluop),
    .addr_i(b_addr), .wdata_i(b_wdata), .bus_req_o(b_req), .bus_we_o(b_we),
    .bus_addr_o(b_baddr), .bus_sel_o(b_sel), .bus_wdata_o(b_bwdata),
    .bus_rdata_i(b_rdata), .bus_ack_i(b_ack), .stall_req_o(b_stall),
    .res_valid_o(b_rv), .res_data_o(b_res), .err_o(b_err), .llbit_o(b_ll)
  );

  typedef struct {
    int          stall;  // cycles with stall_req_o high
    int          reqc;   // cycles with bus_req_o high
    int          lat;    // cycle index (accept = 0) of res_valid_o, -1 if none
    logic [7:0]  sel;
    logic [63:0] bwd;
    logic [31:0] baddr;
    logic        we;
    logic [31:0] res;
    logic        err;
  } txn_t;

  int checks = 0;
  int errors = 0;
  int bad_err = 0;   // err_o seen without res_valid_o
  int bad_sel = 0;   // bus_sel_o nonzero without bus_req_o

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((!a_rv && a_err) || (!b_rv && b_err)) bad_err++;
      if ((!a_req && a_sel != 4'h0) || (!b_req && b_sel != 8'h00)) bad_sel++;
    end
  end

  // Issue one op at the current cycle (caller is 1 ns after a rising edge),
  // ack after 'waits' REQ cycles without ack (-1 = never), observe up to 12 cycles.
  task automatic run(input bit wide, input logic [7:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [63:0] rd, input int waits,
                     output txn_t t);
    logic st, rq, rv, e, we;
    t = '{default: 0};
    t.lat = -1;
    for (int c = 0; c < 12 && t.lat < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (wide) begin
        b_op_valid = (c == 0); b_aluop = op; b_addr = addr; b_wdata = wd; b_rdata = rd;
        b_ack = b_req && (t.reqc == waits);
      end else begin
        a_op_valid = (c == 0); a_aluop = op; a_addr = addr; a_wdata = wd; a_rdata = rd[31:0];
        a_ack = a_req && (t.reqc == waits);
      end
      @(negedge clk);
      st = wide ? b_stall : a_stall;
      rq = wide ? b_req : a_req;
      rv = wide ? b_rv : a_rv;
      e  = wide ? b_err : a_err;
      we = wide ? b_we : a_we;
      if (st) t.stall++;
      if (rq) begin
        t.reqc++;
        t.sel   = wide ? b_sel : {4'h0, a_sel};
        t.bwd   = wide ? b_bwdata : {32'h0, a_bwdata};
        t.baddr = wide ? b_baddr : a_baddr;
        t.we    = we;
      end
      if (rv) begin
        t.lat = c;
        t.res = wide ? b_res : a_res;
        t.err = e;
      end
    end
    a_op_valid = 1'b0; b_op_valid = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    @(posedge clk);
    #1;
    $display("txn dw=%0d op=%h addr=%h stall=%0d req=%0d lat=%0d sel=%h wdata=%h res=%h err=%0d",
             wide ? 64 : 32, op, addr, t.stall, t.reqc, t.lat, t.sel, t.bwd, t.res, t.err);
  endtask

  txn_t t;

  initial begin
    rst = 1'b1;
    a_op_valid = 1'b0; a_ack = 1'b0; a_aluop = 8'h0; a_addr = '0; a_wdata = '0; a_rdata = '0;
    b_op_valid = 1'b0; b_ack = 1'b0; b_aluop = 8'h0; b_addr = '0; b_wdata = '0; b_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {a_req, b_req}, 2'b00);
    chk("rst_stall", {a_stall, b_stall}, 2'b00);
    chk("rst_valid", {a_rv, b_rv}, 2'b00);
    chk("rst_err_ll", {a_err, b_err, a_ll, b_ll}, 4'h0);
    chk("rst_sel", {a_sel, b_sel}, 12'h000);
    chk("rst_res", a_res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LB, sign-extended, ack on the first REQ cycle
    run(1'b0, OP_LB, 32'h0000_1001, 32'h0, 64'h11F2_3344, 0, t);
    chk("lb_sel", t.sel, 8'h04);
    chk("lb_res", t.res, 32'hFFFF_FFF2);
    chk("lb_latency", t.lat, 2);
    chk("lb_stall", t.stall, 2);
    chk("lb_addr_we", {t.baddr, t.we}, {32'h0000_1001, 1'b0});

    run(1'b0, OP_LBU, 32'h0000_1001, 32'h0, 64'h11F2_3344, 0, t);
    chk("lbu_res", t.res, 32'h0000_00F2);

    run(1'b0, OP_LH, 32'h0000_1002, 32'h0, 64'h1234_8001, 0, t);
    chk("lh_sel", t.sel, 8'h03);
    chk("lh_res", t.res, 32'hFFFF_8001);

    // SH after 3 wait cycles; ack lands exactly where TIMEOUT=4 would fire
    run(1'b0, OP_SH, 32'h0000_2002, 32'hABCD_1234, 64'h0, 3, t);
    chk("sh_sel", t.sel, 8'h03);
    chk("sh_wdata", t.bwd, 64'h1234_1234);
    chk("sh_stall", t.stall, 5);
    chk("sh_req_cycles", t.reqc, 4);
    chk("sh_res_err", {t.res, t.err, t.we}, {32'h0, 1'b0, 1'b1});

    run(1'b0, OP_SB, 32'h0000_5003, 32'h0000_00AB, 64'h0, 0, t);
    chk("sb_sel", t.sel, 8'h01);
    chk("sb_wdata", t.bwd, 64'hABAB_ABAB);

    // Misaligned word and half: no bus cycle, error next cycle
    run(1'b0, OP_LW, 32'h0000_3001, 32'h0, 64'h0, 0, t);
    chk("lw_mis_req", t.reqc, 0);
    chk("lw_mis_latency", t.lat, 1);
    chk("lw_mis_err", {t.err, t.res}, {1'b1, 32'h0});
    chk("lw_mis_stall", t.stall, 1);

    run(1'b0, OP_LH, 32'h0000_3003, 32'h0, 64'h0, 0, t);
    chk("lh_mis_err", {t.err, t.reqc}, {1'b1, 32'd0});

    // Timeout: ack never comes
    run(1'b0, OP_LW, 32'h0000_3000, 32'h0, 64'h5555_5555, -1, t);
    chk("to_req_cycles", t.reqc, 4);
    chk("to_latency", t.lat, 5);
    chk("to_err_res", {t.err, t.res}, {1'b1, 32'h0});

    run(1'b0, OP_LW, 32'h0000_3004, 32'h0, 64'h89AB_CDEF, 1, t);
    chk("lw_res", t.res, 32'h89AB_CDEF);
    chk("lw_latency", t.lat, 3);

    run(1'b0, 8'hFF, 32'h0000_3000, 32'h0, 64'h0, 0, t);
    chk("unknown_stall", t.stall, 0);
    chk("unknown_result", t.lat, -1);

    // 64-bit bus
    run(1'b1, OP_LHU, 32'h0000_0006, 32'h0, 64'h0000_0000_0000_BEEF, 0, t);
    chk("w64_lhu_sel", t.sel, 8'h03);
    chk("w64_lhu_res", t.res, 32'h0000_BEEF);
    chk("w64_lhu_latency", t.lat, 2);

    run(1'b1, OP_SW, 32'h0000_0004, 32'hDEAD_BEEF, 64'h0, 0, t);
    chk("w64_sw_sel", t.sel, 8'h0F);
    chk("w64_sw_wdata", t.bwd, 64'hDEAD_BEEF_DEAD_BEEF);

    run(1'b1, OP_LB, 32'h0000_0000, 32'h0, 64'h8011_2233_4455_6677, 0, t);
    chk("w64_lb_sel", t.sel, 8'h80);
    chk("w64_lb_res", t.res, 32'hFFFF_FF80);

`ifdef MEM_LSU_LLSC_EN
    run(1'b0, OP_LL, 32'h0000_7000, 32'h0, 64'hCAFE_F00D, 0, t);
    chk("ll_res", t.res, 32'hCAFE_F00D);
    chk("ll_bit_set", a_ll, 1'b1);
    run(1'b0, OP_SC, 32'h0000_7000, 32'h0000_0055, 64'h0, 0, t);
    chk("sc1_req_cycles", t.reqc, 1);
    chk("sc1_wdata", t.bwd, 64'h0000_0055);
    chk("sc1_res", t.res, 32'h1);
    chk("sc1_bit_clear", a_ll, 1'b0);
    run(1'b0, OP_SC, 32'h0000_7000, 32'h0000_0066, 64'h0, 0, t);
    chk("sc2_req_cycles", t.reqc, 0);
    chk("sc2_res", {t.res, t.err, 32'(t.lat)}, {32'h0, 1'b0, 32'd1});
    run(1'b0, OP_LL, 32'h0000_7000, 32'h0, 64'h0, 0, t);
    chk("ll2_bit_set", a_ll, 1'b1);
`else
    run(1'b0, OP_LL, 32'h0000_7000, 32'h0, 64'hCAFE_F00D, 0, t);
    chk("ll_ignored", {32'(t.stall), 32'(t.lat)}, {32'd0, 32'hFFFF_FFFF});
    run(1'b0, OP_SC, 32'h0000_7000, 32'h0000_0055, 64'h0, 0, t);
    chk("sc_ignored", {32'(t.stall), 32'(t.lat)}, {32'd0, 32'hFFFF_FFFF});
    chk("llbit_tied", a_ll, 1'b0);
`endif

    // Reset in the middle of a bus cycle
    a_op_valid = 1'b1; a_aluop = OP_LW; a_addr = 32'h0000_6000; a_ack = 1'b0;
    @(posedge clk);
    #1;
    a_op_valid = 1'b0;
    chk("rst_mid_req_pre", a_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_drop", a_req, 1'b0);
    chk("rst_mid_stall_ll", {a_stall, a_ll, a_sel}, 6'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_no_result", {a_rv, a_req}, 2'b00);
    $display("txn rst pulse during LW 0x6000");

    chk("err_only_with_valid", bad_err, 0);
    chk("sel_zero_without_req", bad_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
